// File: rtl/pid_speed_controller_if.sv
// Control/status bundle between the speed controller and its neighbours
// (tachometer interface, gain registers, PWM stage).
interface pid_speed_controller_if #(
  parameter int RPM_W  = 26,
  parameter int DUTY_W = 16,
  parameter int GAIN_W = 16
);
  logic              enable_in;
  logic [GAIN_W-1:0] kp_in;
  logic [GAIN_W-1:0] ki_in;
  logic [GAIN_W-1:0] kd_in;
  logic [RPM_W-1:0]  setpoint_rpm_in;
  logic [RPM_W-1:0]  actual_rpm_in;
  logic              sample_valid_in;
  logic [DUTY_W-1:0] duty_cycle_out;
  logic              duty_valid_out;
  logic              busy_out;
  logic              sat_out;

  modport master (
    output enable_in, kp_in, ki_in, kd_in, setpoint_rpm_in, actual_rpm_in, sample_valid_in,
    input  duty_cycle_out, duty_valid_out, busy_out, sat_out
  );

  modport slave (
    input  enable_in, kp_in, ki_in, kd_in, setpoint_rpm_in, actual_rpm_in, sample_valid_in,
    output duty_cycle_out, duty_valid_out, busy_out, sat_out
  );
endinterface

// File: rtl/pid_speed_controller.sv
// Per-wheel discrete PID speed loop: one update per accepted tachometer sample,
// using a single shared multiplier sequenced over P, I and D terms.
module pid_speed_controller #(
  parameter int RPM_W     = 26,
  parameter int DUTY_W    = 16,
  parameter int GAIN_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int INT_LIM   = 2**20
) (
  input  logic                  clk_in,
  input  logic                  reset_n_in,
  pid_speed_controller_if.slave bus
);

  localparam int E_W   = RPM_W + 1;
  localparam int D_W   = RPM_W + 2;
  localparam int G_W   = GAIN_W + 1;
  localparam int P_W   = G_W + D_W;
  localparam int ACC_W = 50;

  localparam logic signed [D_W-1:0] I_MAX = D_W'(INT_LIM);
  localparam logic signed [D_W-1:0] I_MIN = -I_MAX;

  typedef enum logic [2:0] {IDLE, ERR, MUL_P, MUL_I, MUL_D, OUT} state_t;

  state_t state, state_nxt;

  logic [RPM_W-1:0]        sp_l, act_l;
  logic [GAIN_W-1:0]       kp_l, ki_l, kd_l;
  logic signed [E_W-1:0]   e_reg, e_prev, i_acc;
  logic signed [D_W-1:0]   d_reg;
  logic signed [ACC_W-1:0] acc;
  logic [DUTY_W-1:0]       duty;
  logic                    duty_valid, sat_hi, sat_lo;

  logic signed [E_W-1:0]   e_now, i_next;
  logic signed [D_W-1:0]   d_now, i_cand;
  logic                    windup_hold;
  logic signed [G_W-1:0]   mul_a;
  logic signed [D_W-1:0]   mul_b;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] acc_shift;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!bus.enable_in) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.sample_valid_in) state_nxt = ERR;
        ERR:     state_nxt = MUL_P;
        MUL_P:   state_nxt = MUL_I;
        MUL_I:   state_nxt = MUL_D;
        MUL_D:   state_nxt = OUT;
        OUT:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Error, derivative and clamped integrator candidate, all from latched operands.
  always_comb begin
    e_now  = {1'b0, sp_l} - {1'b0, act_l};
    d_now  = {e_now[E_W-1], e_now} - {e_prev[E_W-1], e_prev};
    i_cand = {i_acc[E_W-1], i_acc} + {e_now[E_W-1], e_now};
    if (i_cand > I_MAX)      i_next = I_MAX[E_W-1:0];
    else if (i_cand < I_MIN) i_next = I_MIN[E_W-1:0];
    else                     i_next = i_cand[E_W-1:0];
    windup_hold = (sat_hi && !e_now[E_W-1] && (e_now != '0)) || (sat_lo && e_now[E_W-1]);
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MUL_P: begin
        mul_a = {1'b0, kp_l};
        mul_b = {e_reg[E_W-1], e_reg};
      end
      MUL_I: begin
        mul_a = {1'b0, ki_l};
        mul_b = {i_acc[E_W-1], i_acc};
      end
      MUL_D: begin
        mul_a = {1'b0, kd_l};
        mul_b = d_reg;
      end
      default: ;
    endcase
    prod      = P_W'(mul_a) * P_W'(mul_b);
    acc_shift = acc >>> FRAC_BITS;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sp_l       <= '0;
      act_l      <= '0;
      kp_l       <= '0;
      ki_l       <= '0;
      kd_l       <= '0;
      e_reg      <= '0;
      e_prev     <= '0;
      i_acc      <= '0;
      d_reg      <= '0;
      acc        <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      sat_hi     <= 1'b0;
      sat_lo     <= 1'b0;
    end else if (!bus.enable_in) begin
      // Disabled: abandon any update in flight and restart the loop from rest.
      duty       <= '0;
      duty_valid <= 1'b0;
      sat_hi     <= 1'b0;
      sat_lo     <= 1'b0;
      i_acc      <= '0;
      e_prev     <= '0;
    end else begin
      duty_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.sample_valid_in) begin
            sp_l  <= bus.setpoint_rpm_in;
            act_l <= bus.actual_rpm_in;
            kp_l  <= bus.kp_in;
            ki_l  <= bus.ki_in;
            kd_l  <= bus.kd_in;
          end
        end
        ERR: begin
          e_reg <= e_now;
          d_reg <= d_now;
          if (!windup_hold) i_acc <= i_next;
        end
        MUL_P: acc <= ACC_W'(prod);
        MUL_I: acc <= acc + ACC_W'(prod);
        MUL_D: acc <= acc + ACC_W'(prod);
        OUT: begin
          if (acc_shift[ACC_W-1]) begin
            duty   <= '0;
            sat_hi <= 1'b0;
            sat_lo <= 1'b1;
          end else if (|acc_shift[ACC_W-2:DUTY_W]) begin
            duty   <= '1;
            sat_hi <= 1'b1;
            sat_lo <= 1'b0;
          end else begin
            duty   <= acc_shift[DUTY_W-1:0];
            sat_hi <= 1'b0;
            sat_lo <= 1'b0;
          end
          duty_valid <= 1'b1;
          e_prev     <= e_reg;
        end
        default: ;
      endcase
    end
  end

  assign bus.duty_cycle_out = duty;
  assign bus.duty_valid_out = duty_valid;
  assign bus.sat_out        = sat_hi | sat_lo;
  assign bus.busy_out       = (state != IDLE);

endmodule

// File: tb/tb_pid_speed_controller.sv
// Randomized self-checking bench for pid_speed_controller against an
// integer-arithmetic PID reference model.
module tb_pid_speed_controller;

  localparam int RPM_W   = 26;
  localparam int DUTY_W  = 16;
  localparam int GAIN_W  = 16;
  localparam longint LIM = 2**20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pid_speed_controller_if #(.RPM_W(RPM_W), .DUTY_W(DUTY_W), .GAIN_W(GAIN_W)) bus ();

  pid_speed_controller #(
    .RPM_W(RPM_W), .DUTY_W(DUTY_W), .GAIN_W(GAIN_W), .FRAC_BITS(8), .INT_LIM(2**20)
  ) dut (
    .clk_in(clk),
    .reset_n_in(rst_n),
    .bus(bus)
  );

  // Reference model state
  longint m_i, m_eprev, m_duty;
  bit     m_sh, m_sl;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_i = 0; m_eprev = 0; m_duty = 0; m_sh = 0; m_sl = 0;
  endtask

  task automatic model_update(input longint sp, act, kp, ki, kd);
    longint e, d, c, acc, u;
    e = sp - act;
    d = e - m_eprev;
    if (!((m_sh && e > 0) || (m_sl && e < 0))) begin
      c = m_i + e;
      if (c > LIM) c = LIM;
      else if (c < -LIM) c = -LIM;
      m_i = c;
    end
    acc = kp * e + ki * m_i + kd * d;
    u = acc >>> 8;
    if (u < 0) begin
      m_duty = 0; m_sh = 0; m_sl = 1;
    end else if (u > 65535) begin
      m_duty = 65535; m_sh = 1; m_sl = 0;
    end else begin
      m_duty = u; m_sh = 0; m_sl = 0;
    end
    m_eprev = e;
  endtask

  task automatic scramble_inputs();
    bus.setpoint_rpm_in = RPM_W'($urandom);
    bus.actual_rpm_in   = RPM_W'($urandom);
    bus.kp_in           = GAIN_W'($urandom);
    bus.ki_in           = GAIN_W'($urandom);
    bus.kd_in           = GAIN_W'($urandom);
  endtask

  // mode 0: single strobe; 1: extra strobe while busy; 2: enable dropped after edge N+j
  task automatic run_update(input int sp, act, kp, ki, kd, input int mode, input int j);
    int seen, lat;
    seen = 0; lat = 0;
    @(negedge clk);
    bus.setpoint_rpm_in = RPM_W'(sp);
    bus.actual_rpm_in   = RPM_W'(act);
    bus.kp_in = GAIN_W'(kp); bus.ki_in = GAIN_W'(ki); bus.kd_in = GAIN_W'(kd);
    bus.sample_valid_in = 1'b1;
    @(posedge clk); #1;
    check_val("busy_start", longint'(bus.busy_out), 1);
    @(negedge clk);
    bus.sample_valid_in = 1'b0;
    scramble_inputs();
    for (int k = 1; k <= 14; k++) begin
      if (mode == 1 && k == 2) bus.sample_valid_in = 1'b1;
      if (mode == 1 && k == 3) bus.sample_valid_in = 1'b0;
      if (mode == 2 && k == j + 1) bus.enable_in = 1'b0;
      if (mode == 2 && k == 7) bus.sample_valid_in = 1'b1;
      if (mode == 2 && k == 8) bus.sample_valid_in = 1'b0;
      @(posedge clk); #1;
      if (bus.duty_valid_out) begin
        seen++;
        if (lat == 0) lat = k;
      end
      if (mode != 2 && k == 4) check_val("busy_mid", longint'(bus.busy_out), 1);
      if (mode != 2 && k == 5) check_val("busy_end", longint'(bus.busy_out), 0);
      @(negedge clk);
    end
    if (mode != 2) begin
      model_update(sp, act, kp, ki, kd);
      check_val("latency", lat, 5);
      check_val("pulses", seen, 1);
      check_val("duty", longint'(bus.duty_cycle_out), m_duty);
      check_val("sat", longint'(bus.sat_out), longint'(m_sh | m_sl));
    end else begin
      model_clear();
      check_val("abort_pulses", seen, 0);
      check_val("abort_duty", longint'(bus.duty_cycle_out), 0);
      check_val("abort_sat", longint'(bus.sat_out), 0);
      check_val("abort_busy", longint'(bus.busy_out), 0);
      bus.enable_in = 1'b1;
    end
  endtask

  task automatic reset_mid(input int sp, act, kp, ki, kd);
    @(negedge clk);
    bus.setpoint_rpm_in = RPM_W'(sp);
    bus.actual_rpm_in   = RPM_W'(act);
    bus.kp_in = GAIN_W'(kp); bus.ki_in = GAIN_W'(ki); bus.kd_in = GAIN_W'(kd);
    bus.sample_valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.sample_valid_in = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_val("rst_duty", longint'(bus.duty_cycle_out), 0);
    check_val("rst_valid", longint'(bus.duty_valid_out), 0);
    check_val("rst_busy", longint'(bus.busy_out), 0);
    check_val("rst_sat", longint'(bus.sat_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  function automatic int rand_rpm();
    if ($urandom_range(0, 3) == 3) return int'($urandom & 32'h03FF_FFFF);
    return int'($urandom_range(0, 3000));
  endfunction

  function automatic int rand_gain();
    if ($urandom_range(0, 4) == 0) return ($urandom_range(0, 1) == 1) ? 65535 : 0;
    return int'($urandom_range(0, 600));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sel;
    bus.enable_in = 1'b0;
    bus.sample_valid_in = 1'b0;
    scramble_inputs();
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_duty", longint'(bus.duty_cycle_out), 0);
    check_val("reset_valid", longint'(bus.duty_valid_out), 0);
    check_val("reset_busy", longint'(bus.busy_out), 0);
    check_val("reset_sat", longint'(bus.sat_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.enable_in = 1'b1;

    run_update(1000, 400, 256, 0, 0, 0, 0);
    run_update(400, 1000, 256, 0, 0, 0, 0);
    run_update(100000, 0, 256, 0, 0, 0, 0);
    run_update(0, 0, 0, 0, 0, 2, 1);
    for (int n = 0; n < 3; n++) run_update(1100, 1000, 0, 128, 0, 0, 0);
    run_update(1100, 1000, 0, 65535, 0, 0, 0);
    run_update(1100, 1000, 0, 65535, 0, 0, 0);
    run_update(1000, 1100, 0, 65535, 0, 0, 0);
    run_update(0, 0, 0, 0, 0, 2, 0);
    run_update(100, 0, 0, 0, 256, 0, 0);
    run_update(40, 0, 0, 0, 256, 0, 0);
    run_update(1500, 700, 300, 20, 10, 1, 0);
    run_update(1500, 700, 300, 20, 10, 2, 2);
    run_update(5000, 100, 256, 0, 0, 0, 0);
    reset_mid(3000, 100, 256, 256, 256);
    @(negedge clk);
    bus.enable_in = 1'b1;

    for (int n = 0; n < 250; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 5) begin
        reset_mid(rand_rpm(), rand_rpm(), rand_gain(), rand_gain(), rand_gain());
      end else if (sel < 20) begin
        run_update(rand_rpm(), rand_rpm(), rand_gain(), rand_gain(), rand_gain(), 1, 0);
      end else if (sel < 32) begin
        run_update(rand_rpm(), rand_rpm(), rand_gain(), rand_gain(), rand_gain(), 2,
                   int'($urandom_range(0, 4)));
      end else begin
        run_update(rand_rpm(), rand_rpm(), rand_gain(), rand_gain(), rand_gain(), 0, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pid_speed_controller.md
Name: pid_speed_controller

Overview:
- Closed-loop speed controller between the tachometer interface and the PWM generator; one instance per wheel.
- Consumes the measured RPM and the RPM setpoint, runs a discrete PID update once per new tachometer measurement, and produces the saturated duty-cycle word for the PWM stage.
- Uses a single shared multiplier across a multi-cycle FSM, so each update takes a fixed number of cycles.

Parameters:
- RPM_W, 26, width of the setpoint and measured-RPM words (unsigned).
- DUTY_W, 16, width of the duty-cycle output (unsigned).
- GAIN_W, 16, width of the unsigned fixed-point gains KP, KI, KD.
- FRAC_BITS, 8, number of fractional bits in the gains; the final sum is arithmetic-shifted right by this amount.
- INT_LIM, 2**20, symmetric clamp on the integrator accumulator: ±INT_LIM.

Ports:
- clk_in  in  1  system clock; the block uses this single clock.
- reset_n_in  in  1  asynchronous, active-low reset.
- enable_in  in  1  controller enable; tie to the motor enable.
- kp_in  in  GAIN_W  proportional gain, unsigned Q(GAIN_W-FRAC_BITS).FRAC_BITS.
- ki_in  in  GAIN_W  integral gain, same format.
- kd_in  in  GAIN_W  derivative gain, same format.
- setpoint_rpm_in  in  RPM_W  target RPM.
- actual_rpm_in  in  RPM_W  measured RPM from the tachometer interface.
- sample_valid_in  in  1  single-cycle strobe: actual_rpm_in holds a new measurement.
- duty_cycle_out  out  DUTY_W  registered duty word sent to the PWM stage.
- duty_valid_out  out  1  single-cycle pulse on each duty_cycle_out update.
- busy_out  out  1  high while an update is in progress.
- sat_out  out  1  high when the last update was clamped at 0 or at the maximum.

Behaviour:
- Reset (async assert, sync release): every output is 0; the integrator, e_prev and the FSM state are cleared to 0/IDLE.
- FSM states and transitions:
  - IDLE: on sample_valid_in && enable_in, latch setpoint, actual and the three gains, then go to ERR.
  - ERR: e = setpoint − actual, 27-bit signed; d = e − e_prev; perform the integrator update (rules below).
  - MUL_P: acc = kp·e.
  - MUL_I: acc += ki·I_acc.
  - MUL_D: acc += kd·d.
  - OUT: u = acc >>> FRAC_BITS, then saturate; update duty_cycle_out, pulse duty_valid_out, set e_prev ← e, return to IDLE.
- Latency: duty_cycle_out changes and duty_valid_out pulses exactly 5 cycles after the clock edge that samples sample_valid_in (strobe at edge N → update at edge N+5).
- busy_out is high in every state except IDLE.
- Arithmetic and width rules:
  - Gains are zero-extended to signed.
  - acc is 50-bit signed; no internal overflow is permitted at default widths.
  - The shift is arithmetic, rounding toward −∞.
- Saturation: u < 0 → 0 with sat_out=1; u > 2^DUTY_W−1 → 2^DUTY_W−1 with sat_out=1; otherwise u with sat_out=0.
- Integrator update in ERR:
  - Candidate I_acc + e, clamped to ±INT_LIM.
  - Anti-windup: skip the update if the previous output saturated high and e > 0, or saturated low and e < 0.
- A sample_valid_in arriving while busy is dropped, with no queueing; there is one update per accepted sample.
- First sample after reset or enable uses e_prev = 0.
- enable_in low, at any time including mid-update:
  - Next cycle the FSM returns to IDLE; duty_cycle_out = 0, sat_out = 0, I_acc = 0, e_prev = 0.
  - No duty_valid_out pulse is generated for the aborted update.
- Gains and the setpoint may change at any time; they are sampled only on an accepted strobe.
- Simultaneous strobe and enable falling edge: the strobe is ignored.

Test Plan:
- KP=256, KI=0, KD=0; setpoint 1000, actual 400, one strobe → duty_cycle_out=600 with duty_valid_out at strobe+5, sat_out=0.
- Same gains; setpoint 400, actual 1000 → duty 0, sat_out=1. Then setpoint 100000, actual 0 → duty 65535, sat_out=1.
- KP=0, KI=128, KD=0; constant error 100 over three strobes → I_acc 100/200/300 and duty 50/100/150. Then saturate high with KI=65535; one more positive-error strobe leaves I_acc unchanged (anti-windup).
- KP=0, KI=0, KD=256; errors 100 then 40 → duty 100, then 0 (d = −60 clamped), sat_out=1 on the second update.
- Strobe at cycle T, second strobe at T+2 → exactly one duty_valid_out, at T+5; the second sample is dropped.
- Drop enable_in at T+3 after a strobe → no duty_valid_out, duty 0, integrator 0. Assert reset_n_in low mid-update → all outputs 0 immediately (asynchronous).
